// File: rtl/iomem_responder_if.sv
// Request/response bundle between the memory arbiter (master) and iomem_responder (slave).
// Member names match the original flat ports of the responder.
interface iomem_responder_if #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
);
  logic                iomem_valid_i;
  logic                iomem_ready_o;
  logic [15:0]         iomem_wstrb_i;
  logic [XLEN-1:0]     iomem_addr_i;
  logic [BLK_SIZE-1:0] iomem_wdata_i;
  logic [BLK_SIZE-1:0] iomem_rdata_o;
  logic                err_o;

  modport master (
    output iomem_valid_i, iomem_wstrb_i, iomem_addr_i, iomem_wdata_i,
    input  iomem_ready_o, iomem_rdata_o, err_o
  );

  modport slave (
    input  iomem_valid_i, iomem_wstrb_i, iomem_addr_i, iomem_wdata_i,
    output iomem_ready_o, iomem_rdata_o, err_o
  );
endinterface

// File: rtl/iomem_responder.sv
// Fixed-latency line-granular memory responder: one outstanding request,
// byte-masked writes committed on the response edge, out-of-range flagged with err_o.
module iomem_responder #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128,
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  iomem_responder_if.slave  bus
);
  localparam int AW       = $clog2(DEPTH);
  localparam int NB       = BLK_SIZE / 8;
  localparam int CW       = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int CNT_INIT = (LATENCY > 2) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     addr_q;
  logic [15:0]         wstrb_q;
  logic [BLK_SIZE-1:0] wdata_q;
  logic                ready_q;
  logic                err_q;
  logic [BLK_SIZE-1:0] rdata_q;

  logic [BLK_SIZE-1:0] mem [DEPTH];

  logic [XLEN-1:0]     src_addr;
  logic [15:0]         src_wstrb;
  logic                src_in_range;
  logic [BLK_SIZE-1:0] resp_data;
  logic                q_in_range;

  // With LATENCY=1 the response is loaded straight from the bus on the accept edge.
  always_comb begin
    src_addr  = addr_q;
    src_wstrb = wstrb_q;
    if (state == IDLE) begin
      src_addr  = bus.iomem_addr_i;
      src_wstrb = bus.iomem_wstrb_i;
    end
    src_in_range = (src_addr >> (4 + AW)) == '0;
    resp_data    = '0;
    if (src_in_range && src_wstrb == '0)
      resp_data = mem[src_addr[4 +: AW]];
    q_in_range = (addr_q >> (4 + AW)) == '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iomem_valid_i) begin
            addr_q  <= bus.iomem_addr_i;
            wstrb_q <= bus.iomem_wstrb_i;
            wdata_q <= bus.iomem_wdata_i;
            if (LATENCY == 1) begin
              state   <= RESP;
              ready_q <= 1'b1;
              err_q   <= !src_in_range;
              rdata_q <= resp_data;
            end else begin
              state <= WAIT;
              cnt   <= CW'(CNT_INIT);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= RESP;
            ready_q <= 1'b1;
            err_q   <= !src_in_range;
            rdata_q <= resp_data;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // An asynchronous reset forces IDLE immediately, so an aborted write never reaches this commit.
  always_ff @(posedge clk_i) begin
    if (state == RESP && wstrb_q != '0 && q_in_range) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (wstrb_q[k])
          mem[addr_q[4 +: AW]][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

  assign bus.iomem_ready_o = ready_q;
  assign bus.err_o         = err_q;
  assign bus.iomem_rdata_o = rdata_q;
endmodule
